// File: rtl/scheduler_acc_select_pkg.sv
// Shared sched-info layout for the OmpSs manager accelerator scheduler.
package OmpSsManager;

  localparam int unsigned SCHED_DATA_BITS = 48;

  // One sched-info entry. Accelerators of a type occupy the contiguous ID range
  // first_acc .. first_acc+count_m1, and rr_offset is the next candidate to try.
  typedef struct packed {
    logic [31:0] task_type;
    logic [7:0]  first_acc;
    logic [3:0]  count_m1;
    logic [3:0]  rr_offset;
  } sched_info_t;

endpackage

// File: rtl/scheduler_acc_select.sv
// Round-robin accelerator selector: reads the sched-info entry for a request,
// checks the task type, scans the accelerator range for a free unit, writes
// back the advanced round-robin offset and returns the chosen accelerator ID.
module scheduler_acc_select
  import OmpSsManager::*;
#(
  parameter int unsigned MAX_ACC_TYPES = 16,
  parameter int unsigned ACC_TYPE_BITS = $clog2(MAX_ACC_TYPES),
  parameter int unsigned MAX_ACCS      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ACC_TYPE_BITS-1:0]   req_type_idx,
  input  logic [31:0]                req_task_type,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [7:0]                 rsp_acc_id,
  output logic                       rsp_error,
  input  logic [MAX_ACCS-1:0]        acc_busy,
  output logic [ACC_TYPE_BITS-1:0]   scheduleData_portB_addr,
  output logic                       scheduleData_portB_en,
  input  logic [SCHED_DATA_BITS-1:0] scheduleData_portB_dout,
  output logic [ACC_TYPE_BITS-1:0]   scheduleData_portA_addr,
  output logic                       scheduleData_portA_en,
  output logic [SCHED_DATA_BITS-1:0] scheduleData_portA_din
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_SCAN,
    S_RESP
  } state_t;

  state_t                   state_q;
  logic [ACC_TYPE_BITS-1:0] idx_q;
  logic [31:0]              type_q;
  logic [3:0]               i_q;
  logic                     first_q;
  logic                     portb_en_q;
  logic                     rsp_valid_q;
  logic [7:0]               rsp_acc_q;
  logic                     rsp_err_q;

  sched_info_t entry;
  sched_info_t wr_entry;
  logic [4:0]  count;
  logic [4:0]  sum;
  logic [4:0]  cand;
  logic [4:0]  cand_inc;
  logic [4:0]  i_inc;
  logic [3:0]  i_nxt;
  logic [7:0]  acc;
  logic        acc_free;
  logic        in_scan;
  logic        mismatch;
  logic        grant;

  // Candidate evaluation for the current SCAN cycle; the memory holds dout
  // while en is low, so the entry is taken straight from the read port.
  // The write strobe is combinational because busy is sampled this cycle and
  // the write must land in the same cycle the candidate is found free.
  always_comb begin
    entry    = sched_info_t'(scheduleData_portB_dout);
    count    = {1'b0, entry.count_m1} + 5'd1;
    sum      = {1'b0, entry.rr_offset} + {1'b0, i_q};
    cand     = sum % count;
    cand_inc = cand + 5'd1;
    if (cand_inc == count) begin
      cand_inc = '0;
    end
    i_inc = {1'b0, i_q} + 5'd1;
    i_nxt = (i_inc == count) ? '0 : i_inc[3:0];
    acc   = entry.first_acc + {3'b000, cand};
    // IDs outside the busy vector read as free
    acc_free = (acc_busy & (MAX_ACCS'(1) << acc)) == '0;

    in_scan  = (state_q == S_SCAN) && !rst;
    mismatch = in_scan && first_q && (entry.task_type != type_q);
    grant    = in_scan && !mismatch && acc_free;

    wr_entry           = entry;
    wr_entry.rr_offset = cand_inc[3:0];

    scheduleData_portA_en   = grant;
    scheduleData_portA_addr = grant ? idx_q : '0;
    scheduleData_portA_din  = grant ? wr_entry : '0;
  end

  // Request/response FSM with registered response and read-enable outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      type_q      <= '0;
      i_q         <= '0;
      first_q     <= 1'b0;
      portb_en_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_acc_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            idx_q      <= req_type_idx;
            type_q     <= req_task_type;
            portb_en_q <= 1'b1;
            state_q    <= S_READ;
          end
        end
        S_READ: begin
          portb_en_q <= 1'b0;
          first_q    <= 1'b1;
          i_q        <= '0;
          state_q    <= S_SCAN;
        end
        S_SCAN: begin
          first_q <= 1'b0;
          if (mismatch) begin
            rsp_acc_q   <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (grant) begin
            rsp_acc_q   <= acc;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            i_q <= i_nxt;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready               = (state_q == S_IDLE) && !rst;
  assign rsp_valid               = rsp_valid_q;
  assign rsp_acc_id              = rsp_acc_q;
  assign rsp_error               = rsp_err_q;
  assign scheduleData_portB_en   = portb_en_q;
  assign scheduleData_portB_addr = idx_q;

endmodule

// File: tb/tb_scheduler_acc_select.sv
// Bench for scheduler_acc_select: provides the sched-info memory, drives
// directed and random requests, and predicts results from the selection rules.
module tb_scheduler_acc_select;
  import OmpSsManager::*;

  localparam int unsigned NT = 16;
  localparam int unsigned TB = 4;
  localparam int unsigned NA = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [TB-1:0] req_type_idx;
  logic [31:0]   req_task_type;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [7:0]    rsp_acc_id;
  logic          rsp_error;
  logic [NA-1:0] acc_busy;
  logic [TB-1:0] pb_addr;
  logic          pb_en;
  logic [47:0]   pb_dout;
  logic [TB-1:0] pa_addr;
  logic          pa_en;
  logic [47:0]   pa_din;

  logic          ld_en;
  logic [TB-1:0] ld_addr;
  logic [47:0]   ld_data;
  logic [47:0]   mem [NT];
  logic [47:0]   mdl [NT];
  int            wr_cnt = 0;
  logic [TB-1:0] last_wr_addr;
  logic [47:0]   last_wr_din;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scheduler_acc_select #(.MAX_ACC_TYPES(NT), .ACC_TYPE_BITS(TB), .MAX_ACCS(NA)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_type_idx(req_type_idx), .req_task_type(req_task_type),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_acc_id(rsp_acc_id), .rsp_error(rsp_error),
    .acc_busy(acc_busy),
    .scheduleData_portB_addr(pb_addr), .scheduleData_portB_en(pb_en),
    .scheduleData_portB_dout(pb_dout),
    .scheduleData_portA_addr(pa_addr), .scheduleData_portA_en(pa_en),
    .scheduleData_portA_din(pa_din)
  );

  // External sched-info memory with a bench-side load path
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    if (pa_en) begin
      mem[pa_addr] <= pa_din;
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= pa_addr;
      last_wr_din  <= pa_din;
    end
    if (pb_en) pb_dout <= mem[pb_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [TB-1:0] idx, input logic [47:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = idx; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
    mdl[idx] = d;
  endtask

  // Reference: cycle m after the handshake (m>=2) tries the (m-2)th candidate
  // in round-robin order; the response appears one cycle after the decision.
  task automatic predict(input logic [47:0] e, input logic [31:0] ty,
                         input logic [NA-1:0] b0, input int rel, input logic [NA-1:0] b1,
                         output int lat, output logic [7:0] acc, output logic err,
                         output logic [47:0] ne);
    int cnt;
    int rr;
    int first;
    cnt = int'(e[7:4]) + 1;
    rr = int'(e[3:0]);
    first = int'(e[15:8]);
    err = 1'b0; acc = '0; ne = e; lat = -1;
    if (e[47:16] != ty) begin
      err = 1'b1; lat = 3;
      return;
    end
    for (int m = 2; m < 400; m++) begin
      logic [NA-1:0] b;
      int c;
      int a;
      b = (rel > 0 && m >= rel) ? b1 : b0;
      c = (rr + (m - 2)) % cnt;
      a = (first + c) % 256;
      if (a >= int'(NA) || !b[a]) begin
        acc = 8'(a);
        lat = m + 1;
        ne = {e[47:4], 4'((c + 1) % cnt)};
        return;
      end
    end
  endtask

  task automatic request(input logic [TB-1:0] idx, input logic [31:0] ty,
                         input logic [NA-1:0] b0, input int rel, input logic [NA-1:0] b1,
                         input int hold, input string tag);
    int lat;
    int n;
    int w0;
    logic [7:0] eacc;
    logic eerr;
    logic [47:0] ne;
    bit done;
    predict(mdl[idx], ty, b0, rel, b1, lat, eacc, eerr, ne);
    @(negedge clk);
    acc_busy = b0; req_valid = 1'b1; req_type_idx = idx; req_task_type = ty;
    w0 = wr_cnt;
    chk({tag, "_req_ready_idle"}, 64'(req_ready), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0; req_task_type = $urandom; req_type_idx = TB'($urandom);
    n = 0; done = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      if (rel > 0 && n == rel) acc_busy = b1;
      if (n == 1) begin
        chk({tag, "_portB_en_read"}, 64'(pb_en), 64'd1);
        chk({tag, "_portB_addr"}, 64'(pb_addr), 64'(idx));
      end
      if (n == 2) chk({tag, "_portB_en_scan"}, 64'(pb_en), 64'd0);
      if (rsp_valid) done = 1;
      else if (n <= 3) chk({tag, "_req_ready_busy"}, 64'(req_ready), 64'd0);
    end
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_acc_id"}, 64'(rsp_acc_id), 64'(eacc));
    chk({tag, "_error"}, 64'(rsp_error), 64'(eerr));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
      chk({tag, "_hold_acc"}, 64'(rsp_acc_id), 64'(eacc));
      chk({tag, "_hold_err"}, 64'(rsp_error), 64'(eerr));
      chk({tag, "_hold_req_ready"}, 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    chk({tag, "_req_ready_resp"}, 64'(req_ready), 64'd0);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_valid_drop"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_req_ready_back"}, 64'(req_ready), 64'd1);
    chk({tag, "_write_count"}, 64'(wr_cnt - w0), eerr ? 64'd0 : 64'd1);
    if (!eerr) begin
      chk({tag, "_write_addr"}, 64'(last_wr_addr), 64'(idx));
      chk({tag, "_write_data"}, 64'(last_wr_din), 64'(ne));
    end
    mdl[idx] = ne;
  endtask

  initial begin
    int w0;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; acc_busy = '0;
    req_type_idx = '0; req_task_type = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_acc", 64'(rsp_acc_id), 64'd0);
    chk("rst_rsp_err", 64'(rsp_error), 64'd0);
    chk("rst_pa_en", 64'(pa_en), 64'd0);
    chk("rst_pb_en", 64'(pb_en), 64'd0);
    chk("rst_pa_addr", 64'(pa_addr), 64'd0);
    chk("rst_pb_addr", 64'(pb_addr), 64'd0);
    chk("rst_pa_din", 64'(pa_din), 64'd0);
    rst = 1'b0;

    for (int k = 0; k < int'(NT); k++) begin
      logic [3:0] cm1;
      cm1 = 4'($urandom_range(0, 15));
      load(TB'(k), {$urandom, 8'($urandom_range(0, 15 - int'(cm1))), cm1, 4'($urandom_range(0, 15))});
    end

    // Two-accelerator type: round robin alternates 4, 5
    load(4'd3, {32'hCAFE0001, 8'd4, 4'd1, 4'd0});
    request(4'd3, 32'hCAFE0001, '0, 0, '0, 0, "rr_first");
    chk("rr_first_mem", 64'(mem[3][3:0]), 64'd1);
    request(4'd3, 32'hCAFE0001, '0, 0, '0, 0, "rr_second");
    chk("rr_second_mem", 64'(mem[3][3:0]), 64'd0);

    // Task type mismatch
    request(4'd3, 32'hDEAD0000, '0, 0, '0, 0, "mismatch");

    // Busy skip: 10 and 11 busy, offset 2 -> acc 8 after three scan cycles
    load(4'd5, {32'h12345678, 8'd8, 4'd3, 4'd2});
    request(4'd5, 32'h12345678, 16'h0C00, 0, '0, 0, "skip");
    chk("skip_mem_rr", 64'(mem[5][3:0]), 64'd1);

    // All busy, scan wraps until acc 9 frees
    load(4'd5, {32'h12345678, 8'd8, 4'd3, 4'd2});
    request(4'd5, 32'h12345678, 16'h0F00, 12, 16'h0D00, 0, "wrap");
    chk("wrap_mem_rr", 64'(mem[5][3:0]), 64'd2);

    // Response backpressure
    request(4'd3, 32'hCAFE0001, '0, 0, '0, 5, "hold");

    // Single-accelerator type always writes offset 0
    load(4'd6, {32'h00000066, 8'd12, 4'd0, 4'd0});
    request(4'd6, 32'h00000066, '0, 0, '0, 0, "single");

    // Reset in the SCAN cycle aborts the request
    load(4'd7, {32'h77777777, 8'd0, 4'd0, 4'd0});
    @(negedge clk);
    acc_busy = '0; req_valid = 1'b1; req_type_idx = 4'd7; req_task_type = 32'h77777777;
    w0 = wr_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("abort_pa_en", 64'(pa_en), 64'd0);
    @(negedge clk);
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("abort_req_ready_rst", 64'(req_ready), 64'd0);
    rst = 1'b0;
    #1 chk("abort_req_ready_after", 64'(req_ready), 64'd1);
    @(negedge clk);
    chk("abort_rsp_valid_after", 64'(rsp_valid), 64'd0);
    chk("abort_no_write", 64'(wr_cnt - w0), 64'd0);

    // Randomized traffic, mostly back-to-back to a few entries
    for (int k = 0; k < 40; k++) begin
      logic [TB-1:0] idx;
      logic [31:0] ty;
      logic [NA-1:0] b;
      logic [47:0] e;
      int c;
      idx = TB'($urandom_range(0, 3));
      e = mdl[idx];
      ty = ($urandom_range(0, 4) == 0) ? $urandom : e[47:16];
      b = NA'($urandom);
      c = int'($urandom_range(0, int'(e[7:4])));
      b[(int'(e[15:8]) + c) % int'(NA)] = 1'b0;
      request(idx, ty, b, 0, '0, int'($urandom_range(0, 3)), "rnd");
    end

    for (int k = 0; k < int'(NT); k++) chk("final_mem", 64'(mem[k]), 64'(mdl[k]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
